// File: rtl/shreg_ctrl.sv
// shreg_ctrl: command-driven controller for an external 4-bit shift register.
// Accepts one command at a time (LOAD, CLEAR, SHR, SHL, ROTR, ROTL, NOP) and
// sequences the register's sr/sl/ld pins, then pulses done (with err for the
// reserved opcode).
//
// Ports:
//   clk        - clock, all state on rising edge
//   rst        - synchronous active-high reset
//   cmd_valid  - command offered
//   cmd_ready  - controller idle, command will be accepted
//   cmd_op     - opcode (000 NOP, 001 LOAD, 010 SHR, 011 SHL, 100 ROTR,
//                101 ROTL, 110 CLEAR, 111 reserved)
//   cmd_cnt    - shift/rotate count
//   cmd_data   - parallel load word
//   cmd_fill   - serial fill bit for SHR/SHL
//   q_in       - current Q of the controlled register
//   sr/sl/ld   - register control pins (at most one high)
//   d_out      - parallel data to register D
//   d_sr/d_sl  - serial inputs (into Q[3] / Q[0])
//   done/err   - one-cycle completion pulse / reserved-opcode flag
module shreg_ctrl #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [CNT_W-1:0] cmd_cnt,
  input  logic [3:0]       cmd_data,
  input  logic             cmd_fill,
  input  logic [3:0]       q_in,
  output logic             sr,
  output logic             sl,
  output logic             ld,
  output logic [3:0]       d_out,
  output logic             d_sr,
  output logic             d_sl,
  output logic             done,
  output logic             err
);

  localparam logic [2:0] OpNop   = 3'b000;
  localparam logic [2:0] OpLoad  = 3'b001;
  localparam logic [2:0] OpShr   = 3'b010;
  localparam logic [2:0] OpShl   = 3'b011;
  localparam logic [2:0] OpRotr  = 3'b100;
  localparam logic [2:0] OpRotl  = 3'b101;
  localparam logic [2:0] OpClear = 3'b110;
  localparam logic [2:0] OpRsvd  = 3'b111;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  state_e           w_state_next;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_data;
  logic             r_fill;

  logic w_accept;
  logic w_is_shift;

  // Ready is forced low during reset so nothing can be accepted on a reset edge.
  assign cmd_ready = (r_state == StIdle) && !rst;
  assign w_accept  = cmd_valid && cmd_ready;
  assign w_is_shift = (r_op == OpShr) || (r_op == OpShl) ||
                      (r_op == OpRotr) || (r_op == OpRotl);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_op    <= 3'b000;
      r_cnt   <= '0;
      r_data  <= 4'b0000;
      r_fill  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_accept) begin
        r_op   <= cmd_op;
        r_cnt  <= cmd_cnt;
        r_data <= cmd_data;
        r_fill <= cmd_fill;
      end else if (r_state == StRun && w_is_shift && r_cnt != '0) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept) begin
          case (cmd_op)
            OpLoad, OpClear: w_state_next = StRun;
            OpShr, OpShl, OpRotr, OpRotl:
              w_state_next = (cmd_cnt != '0) ? StRun : StDone;
            default: w_state_next = StDone;
          endcase
        end
      end
      StRun: begin
        // Remaining count of 1 means this is the last control cycle.
        if (!w_is_shift || r_cnt <= CNT_W'(1)) w_state_next = StDone;
      end
      StDone:  w_state_next = StIdle;
      default: w_state_next = StIdle;
    endcase
  end

  // Controls depend only on registered state; d_sr/d_sl for rotates follow q_in.
  always_comb begin
    sr    = 1'b0;
    sl    = 1'b0;
    ld    = 1'b0;
    d_out = 4'b0000;
    d_sr  = 1'b0;
    d_sl  = 1'b0;
    if (r_state == StRun) begin
      case (r_op)
        OpLoad: begin
          ld    = 1'b1;
          d_out = r_data;
        end
        OpClear: ld = 1'b1;
        OpShr: begin
          sr   = 1'b1;
          d_sr = r_fill;
        end
        OpRotr: begin
          sr   = 1'b1;
          d_sr = q_in[0];
        end
        OpShl: begin
          sl   = 1'b1;
          d_sl = r_fill;
        end
        OpRotl: begin
          sl   = 1'b1;
          d_sl = q_in[3];
        end
        default: ;
      endcase
    end
  end

  assign done = (r_state == StDone);
  assign err  = (r_state == StDone) && (r_op == OpRsvd);

endmodule

// File: tb/tb_shreg_ctrl.sv
// Directed bench for shreg_ctrl with a behavioural 4-bit shift register on its
// control outputs. Inputs are driven just after posedge, outputs sampled at negedge.
module tb_shreg_ctrl;

  localparam int unsigned CNT_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_op;
  logic [CNT_W-1:0] cmd_cnt;
  logic [3:0]       cmd_data;
  logic             cmd_fill;
  logic [3:0]       q_in;
  logic             sr, sl, ld;
  logic [3:0]       d_out;
  logic             d_sr, d_sl;
  logic             done, err;

  logic [3:0] m_q = 4'b0000;
  int n_chk  = 0;
  int n_fail = 0;

  shreg_ctrl #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_cnt   (cmd_cnt),
    .cmd_data  (cmd_data),
    .cmd_fill  (cmd_fill),
    .q_in      (q_in),
    .sr        (sr),
    .sl        (sl),
    .ld        (ld),
    .d_out     (d_out),
    .d_sr      (d_sr),
    .d_sl      (d_sl),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Controlled register: Q[3] fed by d_sr on right shift, Q[0] by d_sl on left shift.
  always @(posedge clk) begin
    if (ld)      m_q <= d_out;
    else if (sr) m_q <= {d_sr, m_q[3:1]};
    else if (sl) m_q <= {m_q[2:0], d_sl};
  end
  assign q_in = m_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge while idle; offers the command across one posedge and
  // then scrambles the command inputs, which must have no effect.
  task automatic send(input logic [2:0] op, input logic [CNT_W-1:0] cnt,
                      input logic [3:0] data, input logic fill);
    chk("ready_before_send", {31'b0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_cnt   = cnt;
    cmd_data  = data;
    cmd_fill  = fill;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = 3'b111;
    cmd_cnt   = 3'd5;
    cmd_data  = ~data;
    cmd_fill  = ~fill;
  endtask

  // Checks the sr/sl/ld triple as {sr, sl, ld}.
  task automatic chk_ctl(input string tag, input logic [2:0] exp);
    chk(tag, {29'b0, sr, sl, ld}, {29'b0, exp});
  endtask

  initial begin
    logic [2:0] rotr_dsr;
    rotr_dsr  = 3'b011;  // bit i = expected d_sr in ROTR cycle i from Q=1011
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    cmd_cnt   = '0;
    cmd_data  = 4'b0000;
    cmd_fill  = 1'b0;

    // Reset
    repeat (2) @(negedge clk);
    chk("ready_low_in_rst", {31'b0, cmd_ready}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {31'b0, cmd_ready}, 32'd1);
    chk_ctl("rst_ctl", 3'b000);
    chk("rst_done_err", {30'b0, done, err}, 32'd0);
    chk("rst_dout", {28'b0, d_out}, 32'h0);

    // LOAD 1011
    send(3'b001, 3'd0, 4'b1011, 1'b0);
    @(negedge clk);
    chk_ctl("load_ctl", 3'b001);
    chk("load_dout", {28'b0, d_out}, 32'hb);
    chk("load_nodone", {31'b0, done}, 32'd0);
    @(negedge clk);
    chk("load_done", {30'b0, done, err}, 32'd2);
    chk_ctl("load_ctl_after", 3'b000);
    chk("load_q", {28'b0, m_q}, 32'hb);
    chk("ready_low_done", {31'b0, cmd_ready}, 32'd0);
    @(negedge clk);

    // ROTR cnt=3 from 1011 -> 0111
    send(3'b100, 3'd3, 4'b0000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rotr_ctl", {29'b0, sr, sl, ld}, 32'd4);
      chk("rotr_dsr", {31'b0, d_sr}, {31'b0, rotr_dsr[i]});
      chk("rotr_nodone", {31'b0, done}, 32'd0);
    end
    @(negedge clk);
    chk("rotr_done", {31'b0, done}, 32'd1);
    chk_ctl("rotr_ctl_after", 3'b000);
    chk("rotr_q", {28'b0, m_q}, 32'h7);
    @(negedge clk);

    // CLEAR
    send(3'b110, 3'd4, 4'b1111, 1'b1);
    @(negedge clk);
    chk_ctl("clear_ctl", 3'b001);
    chk("clear_dout", {28'b0, d_out}, 32'h0);
    @(negedge clk);
    chk("clear_done", {31'b0, done}, 32'd1);
    chk("clear_q", {28'b0, m_q}, 32'h0);
    @(negedge clk);

    // SHL cnt=7 fill=1 from 0000 -> 1111, exactly seven pulses
    send(3'b011, 3'd7, 4'b0000, 1'b1);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("shl_ctl", {29'b0, sr, sl, ld}, 32'd2);
      chk("shl_dsl", {31'b0, d_sl}, 32'd1);
    end
    @(negedge clk);
    chk("shl_done", {31'b0, done}, 32'd1);
    chk_ctl("shl_no_8th", 3'b000);
    chk("shl_q", {28'b0, m_q}, 32'hf);
    @(negedge clk);

    // SHR cnt=0: no pulse, done next cycle
    send(3'b010, 3'd0, 4'b0000, 1'b0);
    @(negedge clk);
    chk("shr0_done", {30'b0, done, err}, 32'd2);
    chk_ctl("shr0_ctl", 3'b000);
    chk("shr0_q", {28'b0, m_q}, 32'hf);
    @(negedge clk);

    // Reserved opcode
    send(3'b111, 3'd3, 4'b0000, 1'b0);
    @(negedge clk);
    chk("rsvd_done_err", {30'b0, done, err}, 32'd3);
    chk_ctl("rsvd_ctl", 3'b000);
    chk("rsvd_dout", {28'b0, d_out}, 32'h0);
    @(negedge clk);

    // NOP
    send(3'b000, 3'd2, 4'b1010, 1'b1);
    @(negedge clk);
    chk("nop_done_err", {30'b0, done, err}, 32'd2);
    chk_ctl("nop_ctl", 3'b000);
    @(negedge clk);

    // SHR cnt=2 fill=0 from 1111 -> 0011 (checks fill on right shift)
    send(3'b010, 3'd2, 4'b0000, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("shr_ctl", {29'b0, sr, sl, ld}, 32'd4);
      chk("shr_dsr", {31'b0, d_sr}, 32'd0);
    end
    @(negedge clk);
    chk("shr_done", {31'b0, done}, 32'd1);
    chk("shr_q", {28'b0, m_q}, 32'h3);
    @(negedge clk);

    // ROTL cnt=1 from 0011 -> 0110
    send(3'b101, 3'd1, 4'b0000, 1'b1);
    @(negedge clk);
    chk_ctl("rotl_ctl", 3'b010);
    chk("rotl_dsl", {31'b0, d_sl}, 32'd0);
    @(negedge clk);
    chk("rotl_done", {31'b0, done}, 32'd1);
    chk("rotl_q", {28'b0, m_q}, 32'h6);
    @(negedge clk);

    // Abort: SHL cnt=5 fill=0, reset after 2 pulses; 0110 -> 1000
    send(3'b011, 3'd5, 4'b0000, 1'b0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_ctl_pre", {29'b0, sr, sl, ld}, 32'd2);
    end
    rst = 1'b1;
    @(negedge clk);
    chk_ctl("abort_ctl_low", 3'b000);
    chk("abort_no_done", {31'b0, done}, 32'd0);
    chk("abort_q", {28'b0, m_q}, 32'h8);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_ctl("abort_idle_ctl", 3'b000);
      chk("abort_idle_done", {31'b0, done}, 32'd0);
      chk("abort_ready", {31'b0, cmd_ready}, 32'd1);
    end

    // Reset wins over a simultaneous offer
    rst       = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 3'b001;
    cmd_data  = 4'b0101;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    cmd_valid = 1'b0;
    cmd_op    = 3'b000;
    repeat (2) begin
      @(negedge clk);
      chk_ctl("drop_ctl", 3'b000);
      chk("drop_done", {31'b0, done}, 32'd0);
    end
    chk("drop_q", {28'b0, m_q}, 32'h8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shreg_ctrl.md
SHREG_CTRL -- requirements
Module: shreg_ctrl

Interface
REQ-001 Parameter CNT_W, default 3: width of shift-count field; max count 2^CNT_W-1.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cmd_valid  input  1  command offered.
REQ-005 cmd_ready  output  1  high = controller idle, can accept command.
REQ-006 cmd_op  input  3  000 NOP, 001 LOAD, 010 SHR, 011 SHL, 100 ROTR, 101 ROTL, 110 CLEAR, 111 reserved.
REQ-007 cmd_cnt  input  CNT_W  shift/rotate count; ignored for LOAD, CLEAR and NOP.
REQ-008 cmd_data  input  4  parallel load word for LOAD.
REQ-009 cmd_fill  input  1  serial fill bit for SHR/SHL.
REQ-010 q_in  input  4  current Q of the controlled 4-bit shift register.
REQ-011 sr, sl, ld  output  1 each  control pins of the shift register; at most one high per cycle.
REQ-012 d_out  output  4  parallel data to register D.
REQ-013 d_sr, d_sl  output  1 each  serial inputs to register D_sr (into Q[3]) and D_sl (into Q[0]).
REQ-014 done  output  1  one-cycle pulse, command complete.
REQ-015 err  output  1  one-cycle pulse with done for reserved opcode.

Function
REQ-016 Handshake: command accepted on posedge where cmd_valid & cmd_ready; op, cnt, data, fill latched there.
REQ-017 FSM states IDLE, RUN, DONE; IDLE->RUN on accept of LOAD/CLEAR or of SHR/SHL/ROTR/ROTL with cnt>0; IDLE->DONE on accept of NOP, reserved op, or shift/rotate with cnt=0.
REQ-018 cmd_ready SHALL be high only in IDLE and low while rst is high; cmd_* changes outside accept edges SHALL have no effect.
REQ-019 RUN for LOAD: exactly one cycle with ld=1, d_out=latched data; then DONE.
REQ-020 RUN for CLEAR: exactly one cycle with ld=1, d_out=0000; then DONE.
REQ-021 RUN for shift/rotate: exactly cnt consecutive cycles with the one control high (SHR/ROTR: sr; SHL/ROTL: sl); internal remaining-count register decrements per cycle; RUN->DONE when it reaches 1 in a RUN cycle.
REQ-022 Serial data: SHR d_sr=fill; SHL d_sl=fill; ROTR d_sr=q_in[0]; ROTL d_sl=q_in[3]; combinational from q_in in the same cycle.
REQ-023 sr, sl, ld, d_out SHALL be decoded from registered state only; no combinational path cmd_* -> controls.
REQ-024 Outside RUN: sr=sl=ld=0, d_out=0000, d_sr=d_sl=0.
REQ-025 DONE lasts one cycle with done=1 (err=1 if op was 111), then IDLE; next command acceptable in the cycle after DONE.
REQ-026 Latency: accept at edge k; control cycles k+1..k+n (n=1 LOAD/CLEAR, n=cnt shifts); done in cycle k+n+1; NOP/zero-count/reserved: done in cycle k+1.
REQ-027 Max count 2^CNT_W-1 SHALL complete with no counter wrap or extra control cycle.

Reset
REQ-028 While rst high at a posedge: state->IDLE, remaining count->0, latched fields->0; in the following cycle sr=sl=ld=0, done=err=0, cmd_ready=1.
REQ-029 rst mid-RUN SHALL abort immediately: no further control pulses, no done pulse for the aborted command.
REQ-030 rst has priority over a simultaneous accept; that command is dropped.

Verification
REQ-031 LOAD data=1011 -> one ld cycle, d_out=1011, register Q=1011, done next cycle.
REQ-032 Q=1011, ROTR cnt=3 -> three sr cycles with d_sr=Q[0] each, Q=0111, done one cycle after third sr.
REQ-033 Q=0000, SHL cnt=7 fill=1 -> seven sl cycles, Q=1111, no eighth pulse.
REQ-034 SHR cnt=0 -> no control pulse, done in cycle after accept, Q unchanged.
REQ-035 op=111 -> done and err together one cycle after accept, controls idle.
REQ-036 rst asserted after 2 of 5 SHL cycles -> controls low next cycle, no done, cmd_ready=1 after reset.
